// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the rx line, centre-samples each bit and
// presents good bytes with a one-cycle strobe, flagging bad stop bits.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_connection,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy,
    output logic [2:0] o_receive_state,
    output logic [2:0] o_bit_index
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [CNT_W-1:0] HALF_BIT_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rxMeta;
    logic             r_rxSync;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_counter;
    logic [2:0]       r_bitIndex;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_dataValid;
    logic             r_framingError;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= serial_connection;
            r_rxSync <= r_rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_counter      <= '0;
            r_bitIndex     <= 3'd0;
            r_shift        <= 8'h00;
            r_data         <= 8'h00;
            r_dataValid    <= 1'b0;
            r_framingError <= 1'b0;
        end else begin
            r_dataValid    <= 1'b0;
            r_framingError <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_counter  <= '0;
                    r_bitIndex <= 3'd0;
                    if (!r_rxSync) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: a still-low line confirms a real start bit.
                    if (r_counter == HALF_BIT_LAST) begin
                        r_counter <= '0;
                        r_state   <= r_rxSync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_counter <= r_counter + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_counter == FULL_BIT_LAST) begin
                        r_counter           <= '0;
                        r_shift[r_bitIndex] <= r_rxSync;
                        if (r_bitIndex == 3'd7) begin
                            r_bitIndex <= 3'd0;
                            r_state    <= ST_STOP;
                        end else begin
                            r_bitIndex <= r_bitIndex + 3'd1;
                        end
                    end else begin
                        r_counter <= r_counter + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a directly following start edge be caught.
                    if (r_counter == FULL_BIT_LAST) begin
                        r_counter <= '0;
                        if (r_rxSync) begin
                            r_data      <= r_shift;
                            r_dataValid <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_framingError <= 1'b1;
                            r_state        <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_counter <= r_counter + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    r_counter <= '0;
                    if (r_rxSync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_counter  <= '0;
                    r_bitIndex <= 3'd0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign data            = r_data;
    assign data_valid      = r_dataValid;
    assign framing_error   = r_framingError;
    assign busy            = (r_state != ST_IDLE);
    assign o_receive_state = r_state;
    assign o_bit_index     = r_bitIndex;

endmodule
